ifns_serial_decode_ctrl: RTL and testbench

- Sequential decoder controller for 29-bit IFNS (Fibonacci-weighted) crosstalk-avoidance codewords; produces a 20-bit value.
- Decodes over multiple cycles, consuming LANES code bits per cycle into a running accumulator, so one small adder serves the full word.
- Sits between the bus receiver and the data sink; valid/ready handshake on both sides.

---
 rtl/ifns_serial_decode_ctrl_if.sv | 31 +++
 rtl/ifns_serial_decode_ctrl.sv | 119 +++++++++++
 tb/tb_ifns_serial_decode_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifns_serial_decode_ctrl_if.sv
// Handshake bundle between the bus receiver, the IFNS serial decoder and the data sink.
// The master side is the receiver/sink environment; the slave side is the decoder.
interface ifns_serial_decode_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [28:0] in_code;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_value;
    logic        busy;

    modport master (
        output in_valid,
        output in_code,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_value,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_code,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_value,
        output busy
    );
endinterface

// File: rtl/ifns_serial_decode_ctrl.sv
// Multi-cycle decoder for 29-bit Fibonacci-weighted (IFNS) codewords into a 20-bit value.
// LANES code bits are consumed per cycle into a wrapping 20-bit accumulator.
module ifns_serial_decode_ctrl #(
    parameter int LANES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    ifns_serial_decode_ctrl_if.slave   bus
);

    localparam int CODE_BITS = 29;
    localparam int STEPS     = (CODE_BITS + LANES - 1) / LANES;

    // d29 deliberately weighs 832040 rather than the next Fibonacci number.
    localparam logic [19:0] WEIGHTS [0:CODE_BITS-1] = '{
        20'd1,      20'd1,      20'd2,      20'd3,      20'd5,
        20'd8,      20'd13,     20'd21,     20'd34,     20'd55,
        20'd89,     20'd144,    20'd233,    20'd377,    20'd610,
        20'd987,    20'd1597,   20'd2584,   20'd4181,   20'd6765,
        20'd10946,  20'd17711,  20'd28657,  20'd46368,  20'd75025,
        20'd121393, 20'd196418, 20'd317811, 20'd832040
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [28:0] shift_reg;
    logic [19:0] acc_reg;
    logic [4:0]  cnt_reg;
    logic        out_valid_reg;
    logic [19:0] out_value_reg;
    logic        busy_reg;

    logic [19:0] lane_term [0:LANES-1];
    logic [19:0] sum_next;

    // Lane gi looks at the gi-th unconsumed bit; its absolute code index selects the weight.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0]  idx;
            logic [19:0] weight;

            assign idx = (8'(cnt_reg) * 8'(LANES)) + 8'(gi);

            always_comb begin
                weight = '0;
                if (idx < 8'(CODE_BITS)) begin
                    weight = WEIGHTS[idx[4:0]];
                end
            end

            assign lane_term[gi] = shift_reg[gi] ? weight : 20'd0;
        end
    endgenerate

    always_comb begin
        sum_next = acc_reg;
        for (int i = 0; i < LANES; i++) begin
            sum_next = sum_next + lane_term[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_value_reg <= '0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        shift_reg <= bus.in_code;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    acc_reg   <= sum_next;
                    shift_reg <= shift_reg >> LANES;
                    cnt_reg   <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'(STEPS - 1)) begin
                        out_value_reg <= sum_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    // Gated by rst so no handshake can complete while reset is held.
    assign bus.in_ready  = (state_reg == IDLE) && !rst;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_value = out_value_reg;
    assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_ifns_serial_decode_ctrl.sv
// Directed bench for the IFNS serial decoder: one LANES=1 and one LANES=4 instance.
module tb_ifns_serial_decode_ctrl;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        in_valid;
    logic [28:0] in_code;
    logic        out_ready;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [19:0] s_out_value;
    logic        s_busy;

    int pass_cnt;
    int total_cnt;

    ifns_serial_decode_ctrl_if if1 ();
    ifns_serial_decode_ctrl_if if4 ();

    assign if1.in_valid  = in_valid & ~sel;
    assign if1.in_code   = in_code;
    assign if1.out_ready = out_ready & ~sel;
    assign if4.in_valid  = in_valid & sel;
    assign if4.in_code   = in_code;
    assign if4.out_ready = out_ready & sel;

    assign s_in_ready  = sel ? if4.in_ready  : if1.in_ready;
    assign s_out_valid = sel ? if4.out_valid : if1.out_valid;
    assign s_out_value = sel ? if4.out_value : if1.out_value;
    assign s_busy      = sel ? if4.busy      : if1.busy;

    ifns_serial_decode_ctrl #(.LANES(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    ifns_serial_decode_ctrl #(.LANES(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end else begin
            pass_cnt++;
            $display("ok   %s: %0d", name, got);
        end
    endtask

    // Accept one codeword on the selected instance, time its result, then drain it.
    task automatic decode(input string name, input logic [28:0] code, input int lat_exp,
                          input logic [19:0] exp);
        int lat;
        bit seen;
        bit ready_leak;
        lat = 0;
        seen = 0;
        ready_leak = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = code;
        check({name, " in_ready before accept"}, 32'(s_in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_code  = 29'h0AAA_5555;
        while (!seen && lat < 100) begin
            tick();
            lat++;
            if (s_out_valid === 1'b1) seen = 1;
            if (s_in_ready !== 1'b0) ready_leak = 1;
        end
        check({name, " latency"}, 32'(lat), 32'(lat_exp));
        check({name, " value"}, 32'(s_out_value), 32'(exp));
        check({name, " in_ready low while busy"}, 32'(ready_leak), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " out_valid dropped"}, 32'(s_out_valid), 32'd0);
        check({name, " back in IDLE"}, 32'(s_in_ready), 32'd1);
        $display("txn %s code=0x%07h value=%0d latency=%0d", name, code, s_out_value, lat);
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b1;
        in_valid = 1'b1;
        in_code = 29'h1FFF_FFFF;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset in_ready low during rst", 32'(if1.in_ready), 32'd0);
        check("reset out_valid", 32'(if1.out_valid), 32'd0);
        check("reset out_value", 32'(if1.out_value), 32'd0);
        check("reset busy", 32'(if1.busy), 32'd0);
        check("reset busy lanes4", 32'(if4.busy), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("reset in_ready after release", 32'(if1.in_ready), 32'd1);
        check("reset in_ready after release lanes4", 32'(if4.in_ready), 32'd1);
        tick();
        check("reset stays idle", 32'(if1.busy), 32'd0);
    endtask

    task automatic test_single_lane();
        sel = 1'b0;
        tick();
        decode("d1", 29'h000_0001, 29, 20'd1);
        decode("d29", 29'h1000_0000, 29, 20'd832040);
        decode("all_ones_wrap", 29'h1FFF_FFFF, 29, 20'd615503);
    endtask

    task automatic test_backpressure();
        bit unstable;
        sel = 1'b1;
        tick();
        in_valid = 1'b1;
        in_code = 29'h14;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_code = 29'h1F;
        for (int i = 0; i < 8; i++) tick();
        check("lanes4 out_valid after 8", 32'(s_out_valid), 32'd1);
        check("lanes4 value d3+d5", 32'(s_out_value), 32'd7);
        unstable = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (s_out_valid !== 1'b1 || s_out_value !== 20'd7 || s_in_ready !== 1'b0
                || s_busy !== 1'b1) unstable = 1;
        end
        in_valid = 1'b0;
        check("lanes4 hold under backpressure", 32'(unstable), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("lanes4 release in_ready", 32'(s_in_ready), 32'd1);
        check("lanes4 release out_valid", 32'(s_out_valid), 32'd0);
        check("lanes4 value held after release", 32'(s_out_value), 32'd7);
        $display("txn lanes4 code=0x0000014 value=7 held=5");
    endtask

    task automatic test_reset_mid_run();
        bit pulse;
        sel = 1'b0;
        in_valid = 1'b1;
        in_code = 29'h1FFF_FFFF;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("midrun busy before abort", 32'(s_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrun busy after abort", 32'(s_busy), 32'd0);
        check("midrun in_ready after abort", 32'(s_in_ready), 32'd1);
        pulse = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_out_valid === 1'b1) pulse = 1;
        end
        check("midrun no out_valid", 32'(pulse), 32'd0);
        out_ready = 1'b0;
        decode("after_abort_d2", 29'h2, 29, 20'd1);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int n_acc;
        int n_out;
        int acc_cyc [0:3];
        logic [19:0] vals [0:1];
        bit hs;
        bit bad;
        sel = 1'b0;
        cyc = 0;
        n_acc = 0;
        n_out = 0;
        bad = 0;
        vals[0] = '0;
        vals[1] = '0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        in_valid = 1'b1;
        in_code = 29'h8;
        out_ready = 1'b1;
        while (cyc < 200 && n_out < 2) begin
            hs = s_in_ready & in_valid;
            tick();
            cyc++;
            if (hs) begin
                if (n_acc < 4) acc_cyc[n_acc] = cyc;
                n_acc++;
                in_code = 29'h10;
            end
            if (s_busy === 1'b1 && s_in_ready !== 1'b0) bad = 1;
            if (s_out_valid === 1'b1) begin
                vals[n_out] = s_out_value;
                $display("txn b2b output %0d value=%0d cycle=%0d", n_out, s_out_value, cyc);
                n_out++;
            end
        end
        in_valid = 1'b0;
        tick();
        check("b2b output count", 32'(n_out), 32'd2);
        check("b2b first value", 32'(vals[0]), 32'd3);
        check("b2b second value", 32'(vals[1]), 32'd5);
        check("b2b acceptances", 32'(n_acc), 32'd2);
        check("b2b acceptance spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd31);
        check("b2b in_ready low while busy", 32'(bad), 32'd0);
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        sel = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_code = '0;
        out_ready = 1'b0;
        test_reset();
        test_single_lane();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
